// File: rtl/avalon_fb_fill_engine_if.sv
// Bus bundle for the framebuffer fill engine: CSR slave port, SDRAM master port and irq.
// The "master" modport is the engine's view; "slave" is the host/SDRAM side.
interface avalon_fb_fill_engine_if #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32
);
  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address;
  logic [DATAWIDTH-1:0]           slave_writedata;
  logic                           slave_write;
  logic                           slave_read;
  logic                           slave_chipselect;
  logic [DATAWIDTH-1:0]           slave_readdata;
  logic [MASTER_ADDRESSWIDTH-1:0] master_address;
  logic [DATAWIDTH-1:0]           master_writedata;
  logic                           master_write;
  logic                           master_read;
  logic [DATAWIDTH-1:0]           master_readdata;
  logic                           master_readdatavalid;
  logic                           master_waitrequest;
  logic                           irq;

  modport master (
    input  slave_address, slave_writedata, slave_write, slave_read, slave_chipselect,
    output slave_readdata,
    output master_address, master_writedata, master_write, master_read,
    input  master_readdata, master_readdatavalid, master_waitrequest,
    output irq
  );

  modport slave (
    output slave_address, slave_writedata, slave_write, slave_read, slave_chipselect,
    input  slave_readdata,
    input  master_address, master_writedata, master_write, master_read,
    output master_readdata, master_readdatavalid, master_waitrequest,
    input  irq
  );
endinterface

// File: rtl/avalon_fb_fill_engine.sv
// CSR-programmed Avalon master that fills a framebuffer region (solid or red
// gradient) or reads back one word. The region wraps modulo FB_WORDS.
module avalon_fb_fill_engine #(
  parameter int                             MASTER_ADDRESSWIDTH = 32,
  parameter int                             SLAVE_ADDRESSWIDTH  = 3,
  parameter int                             DATAWIDTH           = 32,
  parameter logic [MASTER_ADDRESSWIDTH-1:0] FB_BASE             = 32'h0800_0000,
  parameter int                             FB_WORDS            = 76800,
  parameter int                             CNT_WIDTH           = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_fb_fill_engine_if.master bus
);

  localparam logic [CNT_WIDTH:0] FB_WORDS_C = (CNT_WIDTH+1)'(FB_WORDS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_REQ  = 3'd2,
    S_READ_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Byte address of a framebuffer word index.
  function automatic logic [MASTER_ADDRESSWIDTH-1:0] fb_addr(input logic [CNT_WIDTH-1:0] idx);
    return FB_BASE + (MASTER_ADDRESSWIDTH'(idx) << 2);
  endfunction

  // Next word index, wrapping at the end of the framebuffer.
  function automatic logic [CNT_WIDTH-1:0] idx_inc(input logic [CNT_WIDTH-1:0] idx);
    logic [CNT_WIDTH:0] nxt;
    nxt = {1'b0, idx} + (CNT_WIDTH+1)'(1'b1);
    if (nxt == FB_WORDS_C) return '0;
    else                   return nxt[CNT_WIDTH-1:0];
  endfunction

  state_t                   r_state, w_state_nxt;
  // programmable CSRs
  logic [1:0]               r_mode;
  logic                     r_irq_en;
  logic [CNT_WIDTH-1:0]     r_offset, r_count, r_period;
  logic [23:0]              r_color;
  // status
  logic                     r_done, r_err;
  logic [DATAWIDTH-1:0]     r_rdata;
  logic [CNT_WIDTH-1:0]     r_progress;
  // shadow copy of the in-flight operation
  logic [CNT_WIDTH-1:0]     r_idx, r_remain, r_sh_period, r_period_cnt;
  logic [15:0]              r_sh_gb;
  logic [7:0]               r_red;
  logic [1:0]               r_sh_mode;
  logic                     r_abort_pend;
  // registered outputs
  logic [MASTER_ADDRESSWIDTH-1:0] r_mst_addr;
  logic [DATAWIDTH-1:0]     r_mst_wdata, r_slv_rdata, w_csr_rdata;
  logic                     r_mst_write, r_mst_read, r_irq;

  logic w_csr_wr, w_ctrl_wr, w_start, w_abort_req, w_abort_any, w_bad;
  logic w_beat, w_rd_acc, w_rdv, w_last, w_red_step, w_busy, w_to_err;
  logic [1:0]           w_new_mode;
  logic [CNT_WIDTH-1:0] w_period_eff, w_idx_nxt;

  assign w_csr_wr     = bus.slave_chipselect & bus.slave_write;
  assign w_ctrl_wr    = w_csr_wr & (bus.slave_address == SLAVE_ADDRESSWIDTH'(0));
  assign w_new_mode   = bus.slave_writedata[2:1];
  assign w_start      = w_ctrl_wr & bus.slave_writedata[0] & (r_state == S_IDLE);
  assign w_abort_req  = w_ctrl_wr & bus.slave_writedata[3];
  assign w_abort_any  = r_abort_pend | w_abort_req;
  assign w_bad        = (r_count == '0) | ({1'b0, r_offset} >= FB_WORDS_C) | (w_new_mode == 2'd3);
  assign w_beat       = r_mst_write & ~bus.master_waitrequest;
  assign w_rd_acc     = r_mst_read & ~bus.master_waitrequest;
  assign w_rdv        = (r_state == S_READ_WAIT) & bus.master_readdatavalid;
  assign w_last       = (r_remain == CNT_WIDTH'(1'b1));
  assign w_period_eff = (r_sh_period == '0) ? CNT_WIDTH'(1'b1) : r_sh_period;
  assign w_red_step   = (r_sh_mode == 2'd1) & ((r_period_cnt + CNT_WIDTH'(1'b1)) == w_period_eff);
  assign w_idx_nxt    = idx_inc(r_idx);
  assign w_to_err     = ((r_state == S_WRITE) & w_beat & w_abort_any) | (w_rdv & w_abort_any);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a write beat in flight is never abandoned.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_start)                w_state_nxt = S_IDLE;
        else if (w_bad)              w_state_nxt = S_DONE;
        else if (w_new_mode == 2'd2) w_state_nxt = S_READ_REQ;
        else                         w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (w_beat && (w_last || w_abort_any)) w_state_nxt = S_DONE;
        else                                   w_state_nxt = S_WRITE;
      end
      S_READ_REQ: begin
        if (w_rd_acc) w_state_nxt = S_READ_WAIT;
        else          w_state_nxt = S_READ_REQ;
      end
      S_READ_WAIT: begin
        if (w_rdv) w_state_nxt = S_DONE;
        else       w_state_nxt = S_READ_WAIT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs: busy in every state but IDLE.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_IDLE:  w_busy = 1'b0;
      default: w_busy = 1'b1;
    endcase
  end

  // Programmable CSRs; writes while busy only affect the next operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= 2'd0; r_irq_en <= 1'b0; r_offset <= '0;
      r_count <= '0;  r_color <= 24'h0; r_period <= '0;
    end else if (w_csr_wr) begin
      case (bus.slave_address)
        SLAVE_ADDRESSWIDTH'(0): begin
          r_mode   <= bus.slave_writedata[2:1];
          r_irq_en <= bus.slave_writedata[4];
        end
        SLAVE_ADDRESSWIDTH'(1): r_offset <= bus.slave_writedata[CNT_WIDTH-1:0];
        SLAVE_ADDRESSWIDTH'(2): r_count  <= bus.slave_writedata[CNT_WIDTH-1:0];
        SLAVE_ADDRESSWIDTH'(3): r_color  <= bus.slave_writedata[23:0];
        SLAVE_ADDRESSWIDTH'(4): r_period <= bus.slave_writedata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Operation datapath: shadow latch on start, beat accounting, status and master outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0; r_remain <= '0; r_sh_period <= '0; r_period_cnt <= '0;
      r_sh_gb <= 16'h0; r_red <= 8'h0; r_sh_mode <= 2'd0; r_abort_pend <= 1'b0;
      r_done <= 1'b0; r_err <= 1'b0; r_rdata <= '0; r_progress <= '0;
      r_mst_addr <= '0; r_mst_wdata <= '0; r_mst_write <= 1'b0; r_mst_read <= 1'b0;
    end else begin
      if (w_start) begin
        r_idx        <= r_offset;
        r_remain     <= r_count;
        r_sh_period  <= r_period;
        r_period_cnt <= '0;
        r_sh_gb      <= r_color[15:0];
        r_red        <= r_color[23:16];
        r_sh_mode    <= w_new_mode;
        r_abort_pend <= 1'b0;
        r_done       <= 1'b0;
        r_err        <= w_bad;
        r_progress   <= '0;
        r_mst_addr   <= fb_addr(r_offset);
        r_mst_wdata  <= DATAWIDTH'({8'h00, r_color});
      end else begin
        if (w_busy && w_abort_req) r_abort_pend <= 1'b1;
        if (w_beat) begin
          r_idx      <= w_idx_nxt;
          r_remain   <= r_remain - CNT_WIDTH'(1'b1);
          r_progress <= r_progress + CNT_WIDTH'(1'b1);
          r_mst_addr <= fb_addr(w_idx_nxt);
          if (w_red_step) begin
            r_red        <= r_red + 8'd1;
            r_period_cnt <= '0;
            r_mst_wdata  <= DATAWIDTH'({8'h00, r_red + 8'd1, r_sh_gb});
          end else begin
            r_period_cnt <= r_period_cnt + CNT_WIDTH'(1'b1);
          end
        end
        if (w_rdv) begin
          r_rdata    <= bus.master_readdata;
          r_progress <= CNT_WIDTH'(1'b1);
        end
        if (r_state == S_DONE) r_done <= 1'b1;
        if (w_to_err)          r_err  <= 1'b1;
      end
      r_mst_write <= (w_state_nxt == S_WRITE);
      r_mst_read  <= (w_state_nxt == S_READ_REQ);
    end
  end

  // CSR read mux.
  always_comb begin
    w_csr_rdata = '0;
    case (bus.slave_address)
      SLAVE_ADDRESSWIDTH'(0): w_csr_rdata = DATAWIDTH'({r_irq_en, 1'b0, r_mode, 1'b0});
      SLAVE_ADDRESSWIDTH'(1): w_csr_rdata = DATAWIDTH'(r_offset);
      SLAVE_ADDRESSWIDTH'(2): w_csr_rdata = DATAWIDTH'(r_count);
      SLAVE_ADDRESSWIDTH'(3): w_csr_rdata = DATAWIDTH'(r_color);
      SLAVE_ADDRESSWIDTH'(4): w_csr_rdata = DATAWIDTH'(r_period);
      SLAVE_ADDRESSWIDTH'(5): w_csr_rdata = DATAWIDTH'({r_err, r_done, w_busy});
      SLAVE_ADDRESSWIDTH'(6): w_csr_rdata = r_rdata;
      SLAVE_ADDRESSWIDTH'(7): w_csr_rdata = DATAWIDTH'(r_progress);
      default:                w_csr_rdata = '0;
    endcase
  end

  // Registered CSR read data and interrupt level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slv_rdata <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (bus.slave_chipselect && bus.slave_read) r_slv_rdata <= w_csr_rdata;
      r_irq <= r_irq_en & r_done;
    end
  end

  assign bus.slave_readdata   = r_slv_rdata;
  assign bus.master_address   = r_mst_addr;
  assign bus.master_writedata = r_mst_wdata;
  assign bus.master_write     = r_mst_write;
  assign bus.master_read      = r_mst_read;
  assign bus.irq              = r_irq;

endmodule

// File: tb/tb_avalon_fb_fill_engine.sv
// Scoreboard bench: expected beats are queued when an operation is programmed
// and popped by the SDRAM model as the engine's beats are accepted.
module tb_avalon_fb_fill_engine;
  localparam logic [31:0] FB_BASE  = 32'h0800_0000;
  localparam int          FB_WORDS = 76800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avalon_fb_fill_engine_if bus ();
  avalon_fb_fill_engine dut (.clk(clk), .reset(rst), .bus(bus));

  int          n_checks = 0, n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] rd_exp_addr = 32'h0, rd_data_cfg = 32'h0;
  int          stall_cfg = 0, stall_cnt = 0, rd_lat = 3, rd_cnt = 0;
  int          n_wr_beats = 0, n_rd_beats = 0, n_wr_cycles = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SDRAM model: decides waitrequest at the falling edge, checks beats against the queue.
  initial begin : sdram_model
    logic [63:0] e;
    bus.master_waitrequest   = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata      = 32'h0;
    forever begin
      @(negedge clk);
      bus.master_readdatavalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.master_readdatavalid = 1'b1;
          bus.master_readdata      = rd_data_cfg;
        end
      end
      if (rst) begin
        stall_cnt = 0; rd_cnt = 0; bus.master_waitrequest = 1'b0;
      end else if (bus.master_write) begin
        n_wr_cycles++;
        if (stall_cnt < stall_cfg) begin
          stall_cnt++;
          bus.master_waitrequest = 1'b1;
          if (exp_q.size() > 0) begin
            check_val("stall_addr", bus.master_address, exp_q[0][63:32]);
            check_val("stall_data", bus.master_writedata, exp_q[0][31:0]);
          end
        end else begin
          bus.master_waitrequest = 1'b0;
          stall_cnt = 0;
          n_wr_beats++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("wr_addr", bus.master_address, e[63:32]);
            check_val("wr_data", bus.master_writedata, e[31:0]);
          end else begin
            check_val("unexpected_write", 32'd1, 32'd0);
          end
        end
      end else if (bus.master_read) begin
        if (stall_cnt < stall_cfg) begin
          stall_cnt++;
          bus.master_waitrequest = 1'b1;
        end else begin
          bus.master_waitrequest = 1'b0;
          stall_cnt = 0;
          n_rd_beats++;
          check_val("rd_addr", bus.master_address, rd_exp_addr);
          rd_cnt = rd_lat;
        end
      end else begin
        bus.master_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1;
    bus.slave_address = a; bus.slave_writedata = d;
    @(negedge clk);
    bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.slave_chipselect = 1'b1; bus.slave_read = 1'b1; bus.slave_address = a;
    @(negedge clk);
    bus.slave_chipselect = 1'b0; bus.slave_read = 1'b0;
    d = bus.slave_readdata;
  endtask

  task automatic push_fill(input int off, input int cnt, input logic [23:0] color,
                           input int period, input bit grad);
    int pe, idx;
    logic [7:0]  red;
    logic [31:0] addr;
    pe = (period == 0) ? 1 : period;
    for (int i = 0; i < cnt; i++) begin
      idx  = (off + i) % FB_WORDS;
      red  = color[23:16] + (grad ? 8'(i / pe) : 8'd0);
      addr = FB_BASE + 32'(idx * 4);
      exp_q.push_back({addr, 8'h00, red, color[15:0]});
    end
  endtask

  task automatic start_op(input int off, input int cnt, input logic [23:0] color,
                          input int period, input logic [31:0] ctrl);
    csr_wr(3'd1, 32'(off));
    csr_wr(3'd2, 32'(cnt));
    csr_wr(3'd3, {8'h00, color});
    csr_wr(3'd4, 32'(period));
    csr_wr(3'd0, ctrl);
  endtask

  task automatic wait_idle(output logic [31:0] s);
    s = 32'h1;
    for (int i = 0; i < 3000; i++) begin
      csr_rd(3'd5, s);
      if (s[0] == 1'b0) break;
    end
    check_val("idle_timeout", {31'h0, s[0]}, 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] s, v;
    int base_w, base_r, base_c;
    bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0; bus.slave_read = 1'b0;
    bus.slave_address = 3'd0; bus.slave_writedata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check_val("rst_mwrite", {31'h0, bus.master_write}, 32'h0);
    check_val("rst_mread", {31'h0, bus.master_read}, 32'h0);
    check_val("rst_irq", {31'h0, bus.irq}, 32'h0);
    csr_rd(3'd5, s); check_val("rst_status", s, 32'h0);
    csr_rd(3'd7, s); check_val("rst_progress", s, 32'h0);
    csr_rd(3'd0, s); check_val("rst_ctrl", s, 32'h0);

    // solid fill, no stalls, back-to-back beats
    stall_cfg = 0; base_c = n_wr_cycles;
    push_fill(0, 4, 24'h12FF00, 0, 1'b0);
    start_op(0, 4, 24'h12FF00, 0, 32'h1);
    wait_idle(s); check_val("solid_status", s, 32'h2);
    csr_rd(3'd7, s); check_val("solid_progress", s, 32'd4);
    check_val("solid_q", 32'(exp_q.size()), 32'd0);
    check_val("solid_b2b_cycles", 32'(n_wr_cycles - base_c), 32'd4);

    // wrap at end of framebuffer with 2 stall cycles per beat
    stall_cfg = 2; base_c = n_wr_cycles;
    push_fill(76798, 3, 24'hABCDEF, 0, 1'b0);
    start_op(76798, 3, 24'hABCDEF, 0, 32'h1);
    wait_idle(s); check_val("wrap_status", s, 32'h2);
    csr_rd(3'd7, s); check_val("wrap_progress", s, 32'd3);
    check_val("wrap_q", 32'(exp_q.size()), 32'd0);
    check_val("wrap_cycles", 32'(n_wr_cycles - base_c), 32'd9);

    // gradient, period 2 then period 0
    stall_cfg = 0;
    push_fill(20, 5, 24'h0500FF, 2, 1'b1);
    start_op(20, 5, 24'h0500FF, 2, 32'h3);
    wait_idle(s); check_val("grad2_status", s, 32'h2);
    check_val("grad2_q", 32'(exp_q.size()), 32'd0);
    stall_cfg = 1;
    push_fill(40, 5, 24'h0500FF, 0, 1'b1);
    start_op(40, 5, 24'h0500FF, 0, 32'h3);
    wait_idle(s); check_val("grad0_status", s, 32'h2);
    check_val("grad0_q", 32'(exp_q.size()), 32'd0);

    // readback with irq
    stall_cfg = 1; rd_lat = 3; rd_exp_addr = FB_BASE + 32'd4; rd_data_cfg = 32'hCAFEF00D;
    base_w = n_wr_beats; base_r = n_rd_beats;
    start_op(1, 1, 24'h0, 0, 32'h15);
    wait_idle(s); check_val("rb_status", s, 32'h2);
    csr_rd(3'd6, s); check_val("rb_rdata", s, 32'hCAFEF00D);
    csr_rd(3'd7, s); check_val("rb_progress", s, 32'd1);
    csr_rd(3'd0, s); check_val("rb_ctrl_read", s, 32'h14);
    check_val("rb_reads", 32'(n_rd_beats - base_r), 32'd1);
    check_val("rb_writes", 32'(n_wr_beats - base_w), 32'd0);
    check_val("rb_irq", {31'h0, bus.irq}, 32'h1);
    csr_wr(3'd0, 32'h4);
    @(negedge clk);
    check_val("irq_clear", {31'h0, bus.irq}, 32'h0);

    // parameter errors: no bus traffic
    base_w = n_wr_beats; base_r = n_rd_beats;
    start_op(0, 0, 24'h0, 0, 32'h1);
    wait_idle(s); check_val("err_count0", s, 32'h6);
    csr_rd(3'd7, s); check_val("err_count0_prog", s, 32'd0);
    start_op(FB_WORDS, 1, 24'h0, 0, 32'h1);
    wait_idle(s); check_val("err_offset", s, 32'h6);
    start_op(0, 1, 24'h0, 0, 32'h7);
    wait_idle(s); check_val("err_mode3", s, 32'h6);
    check_val("err_no_writes", 32'(n_wr_beats - base_w), 32'd0);
    check_val("err_no_reads", 32'(n_rd_beats - base_r), 32'd0);

    // start and abort together while idle: start wins
    stall_cfg = 0;
    push_fill(7, 2, 24'h00AA55, 0, 1'b0);
    start_op(7, 2, 24'h00AA55, 0, 32'h9);
    wait_idle(s); check_val("startabort_status", s, 32'h2);
    check_val("startabort_q", 32'(exp_q.size()), 32'd0);

    // start while busy ignored, CSR writes don't disturb the running fill
    stall_cfg = 3;
    push_fill(10, 3, 24'h334455, 0, 1'b0);
    start_op(10, 3, 24'h334455, 0, 32'h1);
    csr_wr(3'd1, 32'h0);
    csr_wr(3'd0, 32'h3);
    wait_idle(s); check_val("busystart_status", s, 32'h2);
    csr_rd(3'd7, s); check_val("busystart_progress", s, 32'd3);
    check_val("busystart_q", 32'(exp_q.size()), 32'd0);
    csr_rd(3'd1, s); check_val("busystart_offset_csr", s, 32'h0);

    // abort during a stalled beat: that beat completes, then done+err
    stall_cfg = 4; base_w = n_wr_beats;
    push_fill(100, 10, 24'h010203, 0, 1'b0);
    start_op(100, 10, 24'h010203, 0, 32'h1);
    v = 32'h1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_wr_beats - base_w >= 1) begin v = 32'h0; break; end
    end
    check_val("abort_wait_timeout", v, 32'h0);
    csr_wr(3'd0, 32'h8);
    wait_idle(s); check_val("abort_status", s, 32'h6);
    csr_rd(3'd7, s); check_val("abort_progress", s, 32'd2);
    check_val("abort_beats", 32'(n_wr_beats - base_w), 32'd2);
    check_val("abort_q_left", 32'(exp_q.size()), 32'd8);
    exp_q.delete();

    // async reset mid-write with waitrequest held high
    stall_cfg = 1000; base_c = n_wr_cycles;
    push_fill(0, 5, 24'h777777, 0, 1'b0);
    start_op(0, 5, 24'h777777, 0, 32'h1);
    v = 32'h1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_wr_cycles - base_c >= 3) begin v = 32'h0; break; end
    end
    check_val("rstmid_wait_timeout", v, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstmid_mwrite", {31'h0, bus.master_write}, 32'h0);
    check_val("rstmid_maddr", bus.master_address, 32'h0);
    check_val("rstmid_irq", {31'h0, bus.irq}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    stall_cfg = 0;
    csr_rd(3'd5, s); check_val("rstmid_status", s, 32'h0);
    csr_rd(3'd2, s); check_val("rstmid_count_csr", s, 32'h0);
    csr_rd(3'd7, s); check_val("rstmid_progress", s, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
